// File: rtl/mandala_pkg.sv
// Shared types and helpers for the mandala renderer: angle modes, config word, ring tint/hit-bit maths.
// Pure declarations; no timing or flow control.
package mandala_pkg;

  localparam int PHASE_W = 8;

  typedef enum logic [1:0] {
    MODE_XOR = 2'd0,
    MODE_SUM = 2'd1,
    MODE_DX  = 2'd2,
    MODE_MAX = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e      mode;
    logic [1:0] speed;
    logic       freeze;
  } cfg_t;

  // Ring colour offset; 21 spreads successive rings across all three channels.
  function automatic logic [5:0] tint(input int k);
    return 6'(((k + 1) * 21) % 64);
  endfunction

  function automatic logic [2:0] hit_idx(input int k, input int off);
    return 3'((k + off) % 8);
  endfunction

endpackage

// File: rtl/mandala_render_pipe_if.sv
// Pixel-stream, config and output bundle between sync generator, renderer and pin mapper.
// Free-running stream: no valid/ready, every clk carries one pixel.
interface mandala_render_pipe_if #(
  parameter int COORD_W = 10
);
  import mandala_pkg::*;

  logic [COORD_W-1:0] hpos;
  logic [COORD_W-1:0] vpos;
  logic               display_on;
  logic               hsync_in;
  logic               vsync_in;
  logic               cfg_valid;
  mode_e              cfg_mode;
  logic [1:0]         cfg_speed;
  logic               cfg_freeze;
  logic [5:0]         rgb;
  logic               hsync_out;
  logic               vsync_out;
  logic [7:0]         frame_count;

  modport master (
    output hpos, vpos, display_on, hsync_in, vsync_in,
    output cfg_valid, cfg_mode, cfg_speed, cfg_freeze,
    input  rgb, hsync_out, vsync_out, frame_count
  );

  modport slave (
    input  hpos, vpos, display_on, hsync_in, vsync_in,
    input  cfg_valid, cfg_mode, cfg_speed, cfg_freeze,
    output rgb, hsync_out, vsync_out, frame_count
  );

endinterface

// File: rtl/mandala_frame_ctrl.sv
// Frame-edge detect, pending/active config shadowing, animation phase and colour frame counter.
// Updates land one clk after the vsync rising edge; no backpressure.
module mandala_frame_ctrl
  import mandala_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync_in,
  input  logic               cfg_valid,
  input  cfg_t               cfg_in,
  output cfg_t               cfg_active,
  output logic [PHASE_W-1:0] phase,
  output logic [7:0]         frame_count
);

  logic               vsync_prev_q, vsync_prev_d;
  cfg_t               pend_q, pend_d;
  cfg_t               act_q, act_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [7:0]         fc_q, fc_d;
  logic               frame_edge;

  always_comb begin
    frame_edge   = vsync_in & ~vsync_prev_q;
    vsync_prev_d = vsync_in;
    pend_d       = cfg_valid ? cfg_in : pend_q;
    act_d        = act_q;
    phase_d      = phase_q;
    fc_d         = fc_q;
    // Counters follow the config that was live during the frame just ended.
    if (frame_edge) begin
      act_d = pend_q;
      if (!act_q.freeze) begin
        phase_d = phase_q + (PHASE_W'(1) << act_q.speed);
        fc_d    = fc_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev_q <= 1'b0;
      pend_q       <= '0;
      act_q        <= '0;
      phase_q      <= '0;
      fc_q         <= '0;
    end else begin
      vsync_prev_q <= vsync_prev_d;
      pend_q       <= pend_d;
      act_q        <= act_d;
      phase_q      <= phase_d;
      fc_q         <= fc_d;
    end
  end

  assign cfg_active  = act_q;
  assign phase       = phase_q;
  assign frame_count = fc_q;

endmodule

// File: rtl/mandala_render_pipe.sv
// Concentric-ring mandala pixel renderer with frame-shadowed config; syncs delay-matched to rgb.
// Fixed 3-clk latency, one pixel per clk, no backpressure.
module mandala_render_pipe
  import mandala_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int COORD_W   = 10,
  parameter int N_LAYERS  = 8,
  parameter int RING_STEP = 20000
) (
  input logic clk,
  input logic rst_n,
  mandala_render_pipe_if.slave bus
);

  localparam int RAD_W = 2 * COORD_W;
  localparam logic [COORD_W-1:0] CX = COORD_W'(H_ACTIVE / 2);
  localparam logic [COORD_W-1:0] CY = COORD_W'(V_ACTIVE / 2);

  cfg_t               cfg_in;
  cfg_t               cfg_act;
  logic [PHASE_W-1:0] phase;
  logic [7:0]         frame_count;

  assign cfg_in = '{mode: bus.cfg_mode, speed: bus.cfg_speed, freeze: bus.cfg_freeze};

  mandala_frame_ctrl u_frame_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .vsync_in    (bus.vsync_in),
    .cfg_valid   (bus.cfg_valid),
    .cfg_in      (cfg_in),
    .cfg_active  (cfg_act),
    .phase       (phase),
    .frame_count (frame_count)
  );

  // Stage 1: distance from screen centre.
  logic [COORD_W-1:0] dx_q, dx_d, dy_q, dy_d;
  logic               de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  // Stage 2: squared radius and animated angle.
  logic [RAD_W-1:0]   radius_q, radius_d;
  logic [7:0]         angle_q, angle_d;
  logic               de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d;
  // Stage 3: output registers.
  logic [5:0]         rgb_q, rgb_d;
  logic               hs3_q, hs3_d, vs3_q, vs3_d;

  logic [7:0]         ang_f;
  logic [COORD_W-1:0] dmax;
  logic [5:0]         base;
  int                 rad_i;

  always_comb begin
    dx_d  = (bus.hpos >= CX) ? (bus.hpos - CX) : (CX - bus.hpos);
    dy_d  = (bus.vpos >= CY) ? (bus.vpos - CY) : (CY - bus.vpos);
    de1_d = bus.display_on;
    hs1_d = bus.hsync_in;
    vs1_d = bus.vsync_in;
  end

  always_comb begin
    radius_d = RAD_W'(dx_q) * RAD_W'(dx_q) + RAD_W'(dy_q) * RAD_W'(dy_q);
    dmax     = (dx_q > dy_q) ? dx_q : dy_q;
    ang_f    = '0;
    unique case (cfg_act.mode)
      MODE_XOR: ang_f = dx_q[7:0] ^ dy_q[7:0];
      MODE_SUM: ang_f = dx_q[7:0] + dy_q[7:0];
      MODE_DX:  ang_f = dx_q[7:0];
      MODE_MAX: ang_f = dmax[7:0];
      default:  ang_f = '0;
    endcase
    angle_d = ang_f + phase;
    de2_d   = de1_q;
    hs2_d   = hs1_q;
    vs2_d   = vs1_q;
  end

  // Rings tile the radius range with inclusive lower bounds, so at most one k matches.
  always_comb begin
    rad_i = int'(radius_q);
    base  = {frame_count[7:6], frame_count[5:4], frame_count[3:2]};
    rgb_d = '0;
    for (int k = 0; k < N_LAYERS; k++) begin
      if (rad_i >= k * RING_STEP && rad_i < (k + 1) * RING_STEP) begin
        if (de2_q && (angle_q[hit_idx(k, 4)] ^ angle_q[hit_idx(k, 6)])) begin
          rgb_d = base + tint(k);
        end
      end
    end
    hs3_d = hs2_q;
    vs3_d = vs2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx_q     <= '0;
      dy_q     <= '0;
      de1_q    <= 1'b0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      radius_q <= '0;
      angle_q  <= '0;
      de2_q    <= 1'b0;
      hs2_q    <= 1'b0;
      vs2_q    <= 1'b0;
      rgb_q    <= '0;
      hs3_q    <= 1'b0;
      vs3_q    <= 1'b0;
    end else begin
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      de1_q    <= de1_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      radius_q <= radius_d;
      angle_q  <= angle_d;
      de2_q    <= de2_d;
      hs2_q    <= hs2_d;
      vs2_q    <= vs2_d;
      rgb_q    <= rgb_d;
      hs3_q    <= hs3_d;
      vs3_q    <= vs3_d;
    end
  end

  assign bus.rgb         = rgb_q;
  assign bus.hsync_out   = hs3_q;
  assign bus.vsync_out   = vs3_q;
  assign bus.frame_count = frame_count;

endmodule
